// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide sequencer.
//   state_t    : sequencer FSM states
//   OP_MUL/DIV : encoding of unit_op
//   REG_ADDR_W : register-file address width
package cpu_pkg;

   localparam int   REG_ADDR_W = 5;
   localparam logic OP_MUL     = 1'b0;
   localparam logic OP_DIV     = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } state_t;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down counter that saturates at zero.
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one unless already zero
//   zero      : count == 0
module cycle_down_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative multiply/divide unit in EX.
// Detects a MUL/DIV op in EX, starts the unit, stalls the front of the
// pipeline until the result is ready, then commits it with a one-cycle
// wb_valid. A watchdog bounds the wait at the expected unit latency.
//   clk, rst        : clock, asynchronous active-high reset
//   ex_valid        : non-bubble instruction in EX
//   ex_is_mul/div   : instruction class (both set -> DIV)
//   ex_rd           : destination register
//   ex_flush        : control-hazard flush
//   unit_done       : unit result valid
//   unit_start      : start pulse (ISSUE)
//   unit_op         : 0 = MUL, 1 = DIV
//   unit_abort      : cancel in-flight op
//   stall_req       : freeze PC, IF/ID, ID/EX
//   wb_valid/wb_rd  : commit strobe and destination
//   busy            : not IDLE
//   timeout_err     : sticky watchdog expiry
module muldiv_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   input  logic                  ex_is_mul,
   input  logic                  ex_is_div,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_flush,
   input  logic                  unit_done,
   output logic                  unit_start,
   output logic                  unit_op,
   output logic                  unit_abort,
   output logic                  stall_req,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

   state_t                state, state_nxt;
   logic                  req;
   logic                  req_op;
   logic                  op_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  cnt_load, cnt_dec, cnt_zero;
   logic                  to_set;

   // Gated by rst so stall_req is 0 while reset is held even if an op
   // still sits in EX.
   assign req    = ex_valid & (ex_is_mul | ex_is_div) & ~ex_flush & ~rst;
   // DIV wins when both class bits are set.
   assign req_op = ex_is_div ? OP_DIV : OP_MUL;

   cycle_down_counter #(.CNT_W(CNT_W)) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (req_op == OP_DIV ? DIV_LOAD : MUL_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // The counter also decrements in ISSUE, so WAIT cycle k sees
   // latency-k and the watchdog expires on exactly the expected done cycle.
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      to_set    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               cnt_load  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_dec   = 1'b1;
            state_nxt = ex_flush ? IDLE : WAIT;
         end
         WAIT: begin
            cnt_dec = 1'b1;
            if (ex_flush)
               state_nxt = IDLE;
            else if (unit_done)
               state_nxt = COMMIT;
            else if (cnt_zero) begin
               to_set    = 1'b1;
               state_nxt = COMMIT;
            end
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Op and destination are captured when the op is accepted and held
   // through commit/abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= OP_MUL;
         rd_q        <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && req) begin
            op_q <= req_op;
            rd_q <= ex_rd;
         end
         if (to_set)
            timeout_err <= 1'b1;
      end
   end

   // Flush in ISSUE/WAIT aborts; in COMMIT the result is older than the
   // flushed instruction and is still written back.
   assign unit_start = (state == ISSUE);
   assign unit_abort = ((state == ISSUE) || (state == WAIT)) && ex_flush;
   assign wb_valid   = (state == COMMIT);
   assign wb_rd      = wb_valid ? rd_q : '0;
   assign unit_op    = op_q;
   assign busy       = (state != IDLE);
   assign stall_req  = ((state == IDLE) && req) || (state == ISSUE) || (state == WAIT);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ex_valid, ex_is_mul, ex_is_div, ex_flush, unit_done;
   logic [4:0] ex_rd;
   logic       unit_start, unit_op, unit_abort, stall_req, wb_valid, busy, timeout_err;
   logic [4:0] wb_rd;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   muldiv_seq_ctrl dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div),
      .ex_rd(ex_rd), .ex_flush(ex_flush), .unit_done(unit_done),
      .unit_start(unit_start), .unit_op(unit_op), .unit_abort(unit_abort),
      .stall_req(stall_req), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .busy(busy), .timeout_err(timeout_err)
   );

   // Cycle numbering: cycle 0 = op first presented in EX; cycle 1 = ISSUE.
   // done_cyc/flush_cyc: cycle in which the input is high (-1 = never).
   typedef struct {
      logic       mul;
      logic       div;
      logic [4:0] rd;
      int         done_cyc;
      int         flush_cyc;
      int         exp_wb_cyc;
      int         exp_ab_cyc;
      int         exp_stall;
      int         exp_to;
      logic       exp_op;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ex_valid = 0; ex_is_mul = 0; ex_is_div = 0; ex_rd = 0;
      ex_flush = 0; unit_done = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic int outs();
      return {unit_start, unit_op, unit_abort, stall_req, wb_valid, wb_rd, busy, timeout_err};
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int wb_cyc = -1, wb_cnt = 0, wb_rd_s = 0, ab_cyc = -1;
      int st_cnt = 0, st_cyc = -1, stall_cnt = 0, op_s = 0, end_c = -1;
      do_reset();
      ex_valid = 1'b1; ex_is_mul = v.mul; ex_is_div = v.div; ex_rd = v.rd;
      for (int c = 0; c < 50; c++) begin
         unit_done = (c == v.done_cyc);
         ex_flush  = (c == v.flush_cyc);
         @(negedge clk);
         if (stall_req) stall_cnt++;
         if (unit_start) begin st_cnt++; st_cyc = c; op_s = unit_op; end
         if (wb_valid) begin wb_cnt++; wb_cyc = c; wb_rd_s = wb_rd; end
         if (unit_abort && ab_cyc < 0) ab_cyc = c;
         @(posedge clk); #1;
         if ((wb_cyc == c || ab_cyc == c) && end_c < 0) begin
            end_c = c;
            ex_valid = 1'b0;
         end
         if (end_c >= 0 && c >= end_c + 2) break;
      end
      unit_done = 0; ex_flush = 0;
      chk($sformatf("v%0d completed", idx), int'(end_c >= 0), 1);
      chk($sformatf("v%0d start_cnt", idx), st_cnt, 1);
      chk($sformatf("v%0d start_cyc", idx), st_cyc, 1);
      chk($sformatf("v%0d unit_op", idx), op_s, int'(v.exp_op));
      chk($sformatf("v%0d wb_cnt", idx), wb_cnt, (v.exp_wb_cyc >= 0) ? 1 : 0);
      chk($sformatf("v%0d wb_cyc", idx), wb_cyc, v.exp_wb_cyc);
      if (v.exp_wb_cyc >= 0)
         chk($sformatf("v%0d wb_rd", idx), wb_rd_s, int'(v.rd));
      chk($sformatf("v%0d abort_cyc", idx), ab_cyc, v.exp_ab_cyc);
      chk($sformatf("v%0d stall_cnt", idx), stall_cnt, v.exp_stall);
      chk($sformatf("v%0d timeout_err", idx), int'(timeout_err), v.exp_to);
      chk($sformatf("v%0d busy_end", idx), int'(busy), 0);
   endtask

   initial begin
      //          mul   div   rd     done flush wb  ab  stall to op
      vecs[0] = '{1'b1, 1'b0, 5'd5,  5,   -1,   6,  -1, 6,    0, 1'b0}; // MUL N=4
      vecs[1] = '{1'b0, 1'b1, 5'd9,  3,   -1,   4,  -1, 4,    0, 1'b1}; // DIV early
      vecs[2] = '{1'b0, 1'b1, 5'd17, -1,  -1,   35, -1, 35,   1, 1'b1}; // DIV timeout
      vecs[3] = '{1'b1, 1'b0, 5'd3,  3,   3,    -1, 3,  4,    0, 1'b0}; // flush+done in WAIT
      vecs[4] = '{1'b1, 1'b0, 5'd31, 2,   -1,   3,  -1, 3,    0, 1'b0}; // minimum latency
      vecs[5] = '{1'b0, 1'b1, 5'd12, -1,  1,    -1, 1,  2,    0, 1'b1}; // flush in ISSUE
      vecs[6] = '{1'b1, 1'b0, 5'd7,  -1,  -1,   6,  -1, 6,    1, 1'b0}; // MUL timeout
      vecs[7] = '{1'b1, 1'b1, 5'd20, 4,   -1,   5,  -1, 5,    0, 1'b1}; // both set -> DIV
      vecs[8] = '{1'b0, 1'b1, 5'd1,  34,  -1,   35, -1, 35,   0, 1'b1}; // done at expiry

      // reset state
      do_reset();
      @(negedge clk);
      chk("reset outputs", outs(), 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // back-to-back MUL (rd 5) then DIV (rd 6), each done one cycle after start
      begin
         logic st[10], wb[10], bz[10], sr[10], op[10];
         logic [4:0] rdv[10];
         int nst = 0, nwb = 0;
         do_reset();
         for (int c = 0; c < 10; c++) begin
            ex_valid  = (c < 8);
            ex_is_mul = (c < 4);
            ex_is_div = (c >= 4 && c < 8);
            ex_rd     = (c < 4) ? 5'd5 : 5'd6;
            unit_done = (c == 2 || c == 6);
            @(negedge clk);
            st[c] = unit_start; wb[c] = wb_valid; bz[c] = busy;
            sr[c] = stall_req; op[c] = unit_op; rdv[c] = wb_rd;
            if (unit_start) nst++;
            if (wb_valid) nwb++;
            @(posedge clk); #1;
         end
         ex_valid = 0; unit_done = 0;
         chk("b2b start_cnt", nst, 2);
         chk("b2b start1", int'(st[1]), 1);
         chk("b2b start2", int'(st[5]), 1);
         chk("b2b op2", int'(op[5]), 1);
         chk("b2b wb_cnt", nwb, 2);
         chk("b2b wb1", int'(wb[3]), 1);
         chk("b2b wb_rd1", int'(rdv[3]), 5);
         chk("b2b wb2", int'(wb[7]), 1);
         chk("b2b wb_rd2", int'(rdv[7]), 6);
         chk("b2b commit stall", int'(sr[3]), 0);
         chk("b2b idle gap busy", int'(bz[4]), 0);
         chk("b2b idle gap stall", int'(sr[4]), 1);
      end

      // async reset in the middle of a DIV wait, op left sitting in EX
      begin
         int nwb = 0;
         do_reset();
         ex_valid = 1; ex_is_div = 1; ex_rd = 5'd8;
         repeat (4) @(posedge clk);
         #1;
         chk("rst pre busy", int'(busy), 1);
         #3 rst = 1'b1;
         #1;
         chk("rst async outputs", outs(), 0);
         chk("rst async busy", int'(busy), 0);
         @(posedge clk); #1;
         ex_valid = 0; ex_is_div = 0;
         rst = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wb_valid) nwb++;
         end
         chk("rst no wb after", nwb, 0);
         chk("rst timeout clear", int'(timeout_err), 0);
         chk("rst busy after", int'(busy), 0);
      end

      // flush coincident with a request in IDLE
      begin
         do_reset();
         ex_valid = 1; ex_is_mul = 1; ex_rd = 5'd4; ex_flush = 1;
         @(negedge clk);
         chk("idle flush stall", int'(stall_req), 0);
         @(posedge clk); #1;
         ex_valid = 0; ex_is_mul = 0; ex_flush = 0;
         @(negedge clk);
         chk("idle flush busy", int'(busy), 0);
         chk("idle flush start", int'(unit_start), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
